vga_timing_gen: RTL and testbench

- Parametrised raster timing generator producing pixel/line counters, sync, blanking and frame/line strobes for the video output path.
- Supports two compile-time timing modes, selectable at run time; a mode change takes effect only on a frame boundary, so a frame is never torn.
- Adds a synchronous reset, per-mode sync polarity, end-of-line/end-of-frame strobes and a frame counter.
- Sits directly on the pixel clock and feeds the pixel pipeline and the VGA pins.

---
 rtl/vga_timing_pkg.sv | 38 +++
 rtl/vga_axis_counter.sv | 41 ++++
 rtl/vga_timing_gen.sv | 108 ++++++++++
 tb/tb_vga_timing_gen.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared raster timing description and the standard mode tables for the
// VGA timing generator.
package vga_timing_pkg;

   typedef struct packed {
      logic [15:0] h_vis;
      logic [15:0] h_fp;
      logic [15:0] h_sp;
      logic [15:0] h_bp;
      logic [15:0] v_vis;
      logic [15:0] v_fp;
      logic [15:0] v_sp;
      logic [15:0] v_bp;
      logic        h_pol;   // 1 = active-high
      logic        v_pol;
   } vga_timing_t;

   localparam vga_timing_t XGA_1024X768 = '{
      h_vis: 16'd1024, h_fp: 16'd24, h_sp: 16'd136, h_bp: 16'd160,
      v_vis: 16'd768,  v_fp: 16'd3,  v_sp: 16'd6,   v_bp: 16'd29,
      h_pol: 1'b0,     v_pol: 1'b0
   };

   localparam vga_timing_t SVGA_800X600 = '{
      h_vis: 16'd800,  h_fp: 16'd40, h_sp: 16'd128, h_bp: 16'd88,
      v_vis: 16'd600,  v_fp: 16'd1,  v_sp: 16'd4,   v_bp: 16'd23,
      h_pol: 1'b1,     v_pol: 1'b1
   };

   function automatic logic [15:0] h_total(input vga_timing_t t);
      return t.h_vis + t.h_fp + t.h_sp + t.h_bp;
   endfunction

   function automatic logic [15:0] v_total(input vga_timing_t t);
      return t.v_vis + t.v_fp + t.v_sp + t.v_bp;
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping counter plus registered visible/sync/last decode.
module vga_axis_counter #(
   parameter int unsigned WIDTH = 11
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH:0]   vis_lim,
   input  logic [WIDTH:0]   sync_lo,
   input  logic [WIDTH:0]   sync_hi,
   input  logic [WIDTH:0]   last_val,
   input  logic             pol,
   output logic [WIDTH-1:0] count,
   output logic             visible,
   output logic             sync_lvl,
   output logic             last
);

   logic [WIDTH-1:0] nxt;
   logic [WIDTH:0]   nxt_w;

   // Flags are decoded from the next count so they land in the same cycle
   // as the count they describe; the decode limits belong to the mode that
   // will be active after this edge.
   always_comb begin
      nxt = count;
      if (rst)
         nxt = '0;
      else if (en)
         nxt = last ? '0 : count + WIDTH'(1);
      nxt_w = {1'b0, nxt};
   end

   always_ff @(posedge clk) begin
      count    <= nxt;
      visible  <= (nxt_w < vis_lim);
      sync_lvl <= ((nxt_w >= sync_lo) && (nxt_w < sync_hi)) ? pol : ~pol;
      last     <= (nxt_w == last_val);
   end

endmodule

// File: rtl/vga_timing_gen.sv
// Two-mode raster timing generator; mode switches only on frame boundaries.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int unsigned H_WIDTH = 11,
   parameter int unsigned V_WIDTH = 10,
   parameter int unsigned F_WIDTH = 16,
   parameter vga_timing_t MODE_A  = XGA_1024X768,
   parameter vga_timing_t MODE_B  = SVGA_800X600
) (
   input  logic               vclock_in,
   input  logic               rst_in,
   input  logic               mode_in,
   output logic [H_WIDTH-1:0] hcount_out,
   output logic [V_WIDTH-1:0] vcount_out,
   output logic               hsync_out,
   output logic               vsync_out,
   output logic               blank_out,
   output logic               line_end_out,
   output logic               frame_end_out,
   output logic [F_WIDTH-1:0] frame_count_out,
   output logic               active_mode_out
);

   localparam logic [H_WIDTH:0] HA_VIS  = (H_WIDTH+1)'(MODE_A.h_vis);
   localparam logic [H_WIDTH:0] HA_SLO  = (H_WIDTH+1)'(MODE_A.h_vis + MODE_A.h_fp);
   localparam logic [H_WIDTH:0] HA_SHI  = (H_WIDTH+1)'(MODE_A.h_vis + MODE_A.h_fp + MODE_A.h_sp);
   localparam logic [H_WIDTH:0] HA_LAST = (H_WIDTH+1)'(h_total(MODE_A) - 16'd1);
   localparam logic [H_WIDTH:0] HB_VIS  = (H_WIDTH+1)'(MODE_B.h_vis);
   localparam logic [H_WIDTH:0] HB_SLO  = (H_WIDTH+1)'(MODE_B.h_vis + MODE_B.h_fp);
   localparam logic [H_WIDTH:0] HB_SHI  = (H_WIDTH+1)'(MODE_B.h_vis + MODE_B.h_fp + MODE_B.h_sp);
   localparam logic [H_WIDTH:0] HB_LAST = (H_WIDTH+1)'(h_total(MODE_B) - 16'd1);
   localparam logic [V_WIDTH:0] VA_VIS  = (V_WIDTH+1)'(MODE_A.v_vis);
   localparam logic [V_WIDTH:0] VA_SLO  = (V_WIDTH+1)'(MODE_A.v_vis + MODE_A.v_fp);
   localparam logic [V_WIDTH:0] VA_SHI  = (V_WIDTH+1)'(MODE_A.v_vis + MODE_A.v_fp + MODE_A.v_sp);
   localparam logic [V_WIDTH:0] VA_LAST = (V_WIDTH+1)'(v_total(MODE_A) - 16'd1);
   localparam logic [V_WIDTH:0] VB_VIS  = (V_WIDTH+1)'(MODE_B.v_vis);
   localparam logic [V_WIDTH:0] VB_SLO  = (V_WIDTH+1)'(MODE_B.v_vis + MODE_B.v_fp);
   localparam logic [V_WIDTH:0] VB_SHI  = (V_WIDTH+1)'(MODE_B.v_vis + MODE_B.v_fp + MODE_B.v_sp);
   localparam logic [V_WIDTH:0] VB_LAST = (V_WIDTH+1)'(v_total(MODE_B) - 16'd1);

   logic               next_mode;
   logic               frame_end;
   logic               h_vis, v_vis, h_last, v_last;
   logic               h_pol, v_pol;
   logic [H_WIDTH:0]   h_vis_lim, h_slo, h_shi, h_lastv;
   logic [V_WIDTH:0]   v_vis_lim, v_slo, v_shi, v_lastv;

   always_comb begin
      next_mode = (rst_in || frame_end) ? mode_in : active_mode_out;
      h_vis_lim = next_mode ? HB_VIS  : HA_VIS;
      h_slo     = next_mode ? HB_SLO  : HA_SLO;
      h_shi     = next_mode ? HB_SHI  : HA_SHI;
      h_lastv   = next_mode ? HB_LAST : HA_LAST;
      v_vis_lim = next_mode ? VB_VIS  : VA_VIS;
      v_slo     = next_mode ? VB_SLO  : VA_SLO;
      v_shi     = next_mode ? VB_SHI  : VA_SHI;
      v_lastv   = next_mode ? VB_LAST : VA_LAST;
      h_pol     = next_mode ? MODE_B.h_pol : MODE_A.h_pol;
      v_pol     = next_mode ? MODE_B.v_pol : MODE_A.v_pol;
   end

   vga_axis_counter #(.WIDTH(H_WIDTH)) u_h (
      .clk      (vclock_in),
      .rst      (rst_in),
      .en       (1'b1),
      .vis_lim  (h_vis_lim),
      .sync_lo  (h_slo),
      .sync_hi  (h_shi),
      .last_val (h_lastv),
      .pol      (h_pol),
      .count    (hcount_out),
      .visible  (h_vis),
      .sync_lvl (hsync_out),
      .last     (h_last)
   );

   vga_axis_counter #(.WIDTH(V_WIDTH)) u_v (
      .clk      (vclock_in),
      .rst      (rst_in),
      .en       (h_last),
      .vis_lim  (v_vis_lim),
      .sync_lo  (v_slo),
      .sync_hi  (v_shi),
      .last_val (v_lastv),
      .pol      (v_pol),
      .count    (vcount_out),
      .visible  (v_vis),
      .sync_lvl (vsync_out),
      .last     (v_last)
   );

   assign frame_end     = h_last & v_last;
   assign frame_end_out = frame_end;
   assign line_end_out  = h_last;
   assign blank_out     = ~(h_vis & v_vis);

   always_ff @(posedge vclock_in) begin
      if (rst_in) begin
         active_mode_out <= mode_in;
         frame_count_out <= '0;
      end else if (frame_end) begin
         active_mode_out <= mode_in;
         frame_count_out <= frame_count_out + F_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized bench for vga_timing_gen on two small timing modes, checked
// against a pixel-position model of the raster.
module tb_vga_timing_gen;
   import vga_timing_pkg::*;

   localparam vga_timing_t TA = '{
      h_vis: 16'd8, h_fp: 16'd2, h_sp: 16'd3, h_bp: 16'd2,
      v_vis: 16'd5, v_fp: 16'd1, v_sp: 16'd2, v_bp: 16'd1,
      h_pol: 1'b0,  v_pol: 1'b0
   };
   localparam vga_timing_t TB = '{
      h_vis: 16'd6, h_fp: 16'd1, h_sp: 16'd2, h_bp: 16'd3,
      v_vis: 16'd4, v_fp: 16'd2, v_sp: 16'd1, v_bp: 16'd3,
      h_pol: 1'b1,  v_pol: 1'b1
   };

   int HV[2] = '{8, 6};
   int HF[2] = '{2, 1};
   int HS[2] = '{3, 2};
   int HB[2] = '{2, 3};
   int VV[2] = '{5, 4};
   int VF[2] = '{1, 2};
   int VS[2] = '{2, 1};
   int VB[2] = '{1, 3};
   int HP[2] = '{0, 1};
   int VP[2] = '{0, 1};

   logic       vclock_in = 1'b0;
   logic       rst_in;
   logic       mode_in;
   logic [3:0] hcount_out;
   logic [3:0] vcount_out;
   logic       hsync_out, vsync_out, blank_out;
   logic       line_end_out, frame_end_out;
   logic [1:0] frame_count_out;
   logic       active_mode_out;

   vga_timing_gen #(
      .H_WIDTH (4),
      .V_WIDTH (4),
      .F_WIDTH (2),
      .MODE_A  (TA),
      .MODE_B  (TB)
   ) dut (
      .vclock_in       (vclock_in),
      .rst_in          (rst_in),
      .mode_in         (mode_in),
      .hcount_out      (hcount_out),
      .vcount_out      (vcount_out),
      .hsync_out       (hsync_out),
      .vsync_out       (vsync_out),
      .blank_out       (blank_out),
      .line_end_out    (line_end_out),
      .frame_end_out   (frame_end_out),
      .frame_count_out (frame_count_out),
      .active_mode_out (active_mode_out)
   );

   always #5 vclock_in = ~vclock_in;

   int n_checks = 0;
   int n_fail   = 0;
   int m_h, m_v, m_mode, m_fc;

   function automatic int ht(input int m);
      return HV[m] + HF[m] + HS[m] + HB[m];
   endfunction

   function automatic int vt(input int m);
      return VV[m] + VF[m] + VS[m] + VB[m];
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s at h=%0d v=%0d: got %0d, expected %0d", tag, m_h, m_v, obs, exp);
      end
   endtask

   task automatic model_update(input logic r, input logic md);
      bit fe;
      if (r) begin
         m_h = 0; m_v = 0; m_fc = 0; m_mode = int'(md);
      end else begin
         fe = (m_h == ht(m_mode) - 1) && (m_v == vt(m_mode) - 1);
         if (m_h == ht(m_mode) - 1) begin
            m_h = 0;
            m_v = (m_v == vt(m_mode) - 1) ? 0 : m_v + 1;
         end else begin
            m_h = m_h + 1;
         end
         if (fe) begin
            m_fc   = (m_fc + 1) % 4;
            m_mode = int'(md);
         end
      end
   endtask

   task automatic step();
      int  m;
      bit  hs_act, vs_act, le;
      @(posedge vclock_in);
      model_update(rst_in, mode_in);
      #1;
      m      = m_mode;
      hs_act = (m_h >= HV[m] + HF[m]) && (m_h < HV[m] + HF[m] + HS[m]);
      vs_act = (m_v >= VV[m] + VF[m]) && (m_v < VV[m] + VF[m] + VS[m]);
      le     = (m_h == ht(m) - 1);
      check_eq("hcount", 32'(hcount_out), 32'(m_h));
      check_eq("vcount", 32'(vcount_out), 32'(m_v));
      check_eq("mode",   32'(active_mode_out), 32'(m));
      check_eq("fcount", 32'(frame_count_out), 32'(m_fc));
      check_eq("blank",  32'(blank_out), 32'((m_h >= HV[m]) || (m_v >= VV[m])));
      check_eq("hsync",  32'(hsync_out), 32'(hs_act ? HP[m] : 1 - HP[m]));
      check_eq("vsync",  32'(vsync_out), 32'(vs_act ? VP[m] : 1 - VP[m]));
      check_eq("lend",   32'(line_end_out), 32'(le));
      check_eq("fend",   32'(frame_end_out), 32'(le && (m_v == vt(m) - 1)));
   endtask

   initial begin
      bit found;
      rst_in  = 1'b1;
      mode_in = 1'b0;
      step();
      rst_in = 1'b0;

      // long unbroken run: frame counter wraps, mode toggles land on frame ends
      for (int i = 0; i < 1500; i++) begin
         step();
         if ($urandom_range(0, 39) == 0) mode_in = ~mode_in;
      end

      // reset in the middle of a frame
      found = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (m_h == 5 && m_v == 3) begin found = 1'b1; break; end
         step();
      end
      check_eq("seek_mid", 32'(found), 32'd1);
      rst_in  = 1'b1;
      mode_in = 1'b1;
      step();
      rst_in = 1'b0;

      // reset coinciding with a frame-end cycle
      found = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (m_h == ht(m_mode) - 1 && m_v == vt(m_mode) - 1) begin found = 1'b1; break; end
         step();
      end
      check_eq("seek_fend", 32'(found), 32'd1);
      rst_in = 1'b1;
      step();
      rst_in = 1'b0;

      for (int i = 0; i < 3000; i++) begin
         step();
         rst_in = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 29) == 0) mode_in = ~mode_in;
      end
      rst_in = 1'b0;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
